// File: rtl/writeback_pkg.sv
// ============================================================================
//  writeback_pkg : shared load-size encodings, FSM state and load context.
//  Revision 1.0
// ============================================================================
`default_nettype none

package writeback_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } wb_state_e;

   typedef struct packed {
      logic [4:0] addr;
      logic       write;
      logic [1:0] size;
      logic       unsgn;
      logic [1:0] offset;
   } ld_ctx_t;

endpackage

`default_nettype wire

// File: rtl/writeback_load_extend.sv
// ============================================================================
//  load_extend : selects the addressed byte/half/word of a memory word and
//  sign- or zero-extends it to 32 bits.  Revision 1.0
// ============================================================================
`default_nettype none

module load_extend
   import writeback_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  offset_i,
   output logic [31:0] value_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        byte_fill;
   logic        half_fill;

   always_comb begin
      byte_sel = data_i[7:0];
      case (offset_i)
         2'd0:    byte_sel = data_i[7:0];
         2'd1:    byte_sel = data_i[15:8];
         2'd2:    byte_sel = data_i[23:16];
         default: byte_sel = data_i[31:24];
      endcase

      // offset[0] is irrelevant for halves: only aligned halves are reachable
      half_sel  = offset_i[1] ? data_i[31:16] : data_i[15:0];
      byte_fill = ~unsigned_i & byte_sel[7];
      half_fill = ~unsigned_i & half_sel[15];

      case (size_i)
         LS_BYTE: value_o = {{24{byte_fill}}, byte_sel};
         LS_HALF: value_o = {{16{half_fill}}, half_sel};
         default: value_o = data_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/writeback.sv
// ============================================================================
//  writeback : registers ALU results or waits for load data, then issues a
//  single-cycle register-file write.  Revision 1.0
// ============================================================================
`default_nettype none

module writeback
   import writeback_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        input_valid_i,
   output logic        input_ready_o,
   input  logic        result_write_i,
   input  logic [4:0]  result_addr_i,
   input  logic [31:0] result_value_i,
   input  logic        load_i,
   input  logic [1:0]  load_size_i,
   input  logic        load_unsigned_i,
   input  logic [1:0]  load_offset_i,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_data_i,
   output logic        reg_write_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o
);

   wb_state_e   state_q,     state_d;
   ld_ctx_t     ctx_q,       ctx_d;
   logic        reg_write_q, reg_write_d;
   logic [4:0]  reg_waddr_q, reg_waddr_d;
   logic [31:0] reg_wdata_q, reg_wdata_d;
   logic [31:0] load_value;
   logic        accept;

   load_extend u_load_extend (
      .data_i     (mem_data_i),
      .size_i     (ctx_q.size),
      .unsigned_i (ctx_q.unsgn),
      .offset_i   (ctx_q.offset),
      .value_o    (load_value)
   );

   assign input_ready_o = (state_q == ST_IDLE);
   assign accept        = input_valid_i && input_ready_o;

   always_comb begin
      state_d     = state_q;
      ctx_d       = ctx_q;
      reg_write_d = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;

      case (state_q)
         ST_IDLE: begin
            // mem_valid_i is deliberately not looked at here
            if (accept) begin
               if (load_i) begin
                  ctx_d.addr   = result_addr_i;
                  ctx_d.write  = result_write_i;
                  ctx_d.size   = load_size_i;
                  ctx_d.unsgn  = load_unsigned_i;
                  ctx_d.offset = load_offset_i;
                  state_d      = ST_WAIT_MEM;
               end else if (result_write_i && (result_addr_i != 5'd0)) begin
                  reg_write_d = 1'b1;
                  reg_waddr_d = result_addr_i;
                  reg_wdata_d = result_value_i;
               end
            end
         end
         ST_WAIT_MEM: begin
            if (mem_valid_i) begin
               state_d = ST_IDLE;
               if (ctx_q.write && (ctx_q.addr != 5'd0)) begin
                  reg_write_d = 1'b1;
                  reg_waddr_d = ctx_q.addr;
                  reg_wdata_d = load_value;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         ctx_q       <= '0;
         reg_write_q <= 1'b0;
         reg_waddr_q <= 5'd0;
         reg_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         ctx_q       <= ctx_d;
         reg_write_q <= reg_write_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   assign reg_write_o = reg_write_q;
   assign reg_waddr_o = reg_waddr_q;
   assign reg_wdata_o = reg_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: stimulus pushes expected writes, a monitor pops them.
`default_nettype none

module tb_writeback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        input_valid = 1'b0;
   logic        input_ready;
   logic        result_write = 1'b0;
   logic [4:0]  result_addr = '0;
   logic [31:0] result_value = '0;
   logic        load = 1'b0;
   logic [1:0]  load_size = '0;
   logic        load_unsigned = 1'b0;
   logic [1:0]  load_offset = '0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_data = '0;
   logic        reg_write;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   writeback dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .input_valid_i   (input_valid),
      .input_ready_o   (input_ready),
      .result_write_i  (result_write),
      .result_addr_i   (result_addr),
      .result_value_i  (result_value),
      .load_i          (load),
      .load_size_i     (load_size),
      .load_unsigned_i (load_unsigned),
      .load_offset_i   (load_offset),
      .mem_valid_i     (mem_valid),
      .mem_data_i      (mem_data),
      .reg_write_o     (reg_write),
      .reg_waddr_o     (reg_waddr),
      .reg_wdata_o     (reg_wdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every write the DUT presents must match the oldest expected write
   initial begin
      logic [36:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (reg_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                        reg_waddr, reg_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({reg_waddr, reg_wdata} !== e) begin
                  errors++;
                  $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                           reg_waddr, reg_wdata, e[36:32], e[31:0]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic idle();
      @(negedge clk);
      input_valid = 1'b0;
      load        = 1'b0;
      mem_valid   = 1'b0;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] v, input logic w);
      @(negedge clk);
      input_valid  = 1'b1;
      load         = 1'b0;
      mem_valid    = 1'b0;
      result_write = w;
      result_addr  = a;
      result_value = v;
      if (w && a != 5'd0) exp_q.push_back({a, v});
   endtask

   task automatic ld(input logic [4:0] a, input logic w, input logic [1:0] sz,
                     input logic uns, input logic [1:0] off, input logic [31:0] d,
                     input int waits, input logic mv_at_accept, input logic [31:0] exp);
      @(negedge clk);
      chk("ready_before_load", {31'd0, input_ready}, 32'd1);
      input_valid   = 1'b1;
      load          = 1'b1;
      result_write  = w;
      result_addr   = a;
      result_value  = 32'hCAFEF00D;
      load_size     = sz;
      load_unsigned = uns;
      load_offset   = off;
      mem_valid     = mv_at_accept;
      mem_data      = 32'h5A5A5A5A;
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         input_valid = 1'b0;
         load        = 1'b0;
         mem_valid   = 1'b0;
         result_addr = 5'd31;
         chk("ready_during_wait", {31'd0, input_ready}, 32'd0);
         chk("no_write_during_wait", {31'd0, reg_write}, 32'd0);
      end
      @(negedge clk);
      input_valid = 1'b0;
      load        = 1'b0;
      mem_valid   = 1'b1;
      mem_data    = d;
      if (w && a != 5'd0) exp_q.push_back({a, exp});
      @(negedge clk);
      mem_valid = 1'b0;
      chk("ready_after_load", {31'd0, input_ready}, 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_write", {31'd0, reg_write}, 32'd0);
      chk("rst_waddr", {27'd0, reg_waddr}, 32'd0);
      chk("rst_wdata", reg_wdata, 32'd0);
      chk("rst_ready", {31'd0, input_ready}, 32'd1);
      rst_n = 1'b1;

      // ALU write, then x0 write (suppressed, outputs hold)
      alu(5'd5, 32'hDEADBEEF, 1'b1);
      alu(5'd0, 32'h12345678, 1'b1);
      idle();
      chk("x0_no_write", {31'd0, reg_write}, 32'd0);
      chk("hold_waddr", {27'd0, reg_waddr}, 32'd5);
      chk("hold_wdata", reg_wdata, 32'hDEADBEEF);

      // Back-to-back ALU, including a write=0 request
      alu(5'd1, 32'h00000001, 1'b1);
      alu(5'd2, 32'h00000002, 1'b1);
      alu(5'd3, 32'h00000003, 1'b0);
      alu(5'd31, 32'hFFFF0000, 1'b1);
      idle();

      // Loads
      ld(5'd7,  1'b1, 2'b00, 1'b0, 2'd2, 32'h0080FF00, 3, 1'b0, 32'hFFFFFF80);
      ld(5'd8,  1'b1, 2'b01, 1'b1, 2'd2, 32'h80011234, 0, 1'b0, 32'h00008001);
      ld(5'd9,  1'b1, 2'b01, 1'b0, 2'd0, 32'h0000F000, 1, 1'b0, 32'hFFFFF000);
      ld(5'd10, 1'b1, 2'b00, 1'b1, 2'd3, 32'hA5000000, 2, 1'b0, 32'h000000A5);
      ld(5'd11, 1'b1, 2'b10, 1'b0, 2'd1, 32'h13579BDF, 1, 1'b0, 32'h13579BDF);
      ld(5'd12, 1'b1, 2'b11, 1'b0, 2'd3, 32'h87654321, 1, 1'b0, 32'h87654321);
      ld(5'd13, 1'b1, 2'b01, 1'b0, 2'd3, 32'h7FFF0000, 1, 1'b0, 32'h00007FFF);
      ld(5'd14, 1'b1, 2'b00, 1'b0, 2'd1, 32'h00007F00, 1, 1'b0, 32'h0000007F);
      ld(5'd15, 1'b0, 2'b10, 1'b0, 2'd0, 32'h11111111, 1, 1'b0, 32'h0);
      ld(5'd0,  1'b1, 2'b10, 1'b0, 2'd0, 32'h22222222, 1, 1'b0, 32'h0);

      // Spurious mem_valid in IDLE and in the load acceptance cycle
      @(negedge clk);
      mem_valid = 1'b1;
      mem_data  = 32'hBADBAD00;
      @(negedge clk);
      mem_valid = 1'b0;
      chk("idle_memvalid_no_write", {31'd0, reg_write}, 32'd0);
      ld(5'd20, 1'b1, 2'b10, 1'b0, 2'd0, 32'h0BADF00D, 2, 1'b1, 32'h0BADF00D);
      idle();

      // Reset while waiting for memory abandons the load
      @(negedge clk);
      input_valid  = 1'b1;
      load         = 1'b1;
      result_write = 1'b1;
      result_addr  = 5'd21;
      load_size    = 2'b10;
      @(negedge clk);
      input_valid = 1'b0;
      load        = 1'b0;
      chk("wait_before_reset", {31'd0, input_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_ready", {31'd0, input_ready}, 32'd1);
      chk("async_rst_waddr", {27'd0, reg_waddr}, 32'd0);
      chk("async_rst_wdata", reg_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_valid = 1'b1;
      mem_data  = 32'h77777777;
      @(negedge clk);
      mem_valid = 1'b0;
      chk("post_rst_no_write", {31'd0, reg_write}, 32'd0);
      chk("post_rst_ready", {31'd0, input_ready}, 32'd1);
      chk("post_rst_waddr", {27'd0, reg_waddr}, 32'd0);
      chk("post_rst_wdata", reg_wdata, 32'd0);

      // First accept right after reset release still works
      alu(5'd6, 32'h600DCAFE, 1'b1);
      repeat (4) idle();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
